// File: rtl/uart_pkg.sv
// Shared UART timing definitions: baud generator state encoding and oversample range limits.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PENDING = 2'd2
  } gen_state_t;

  localparam int OVERSAMPLE_MIN = 2;
  localparam int OVERSAMPLE_MAX = 64;

  function automatic bit os_legal(input int os);
    return (os >= OVERSAMPLE_MIN) && (os <= OVERSAMPLE_MAX) && ((os & (os - 1)) == 0);
  endfunction

endpackage

// File: rtl/frac_accum.sv
// Modulo-MOD phase accumulator; wrap flags (combinationally) the cycle whose sum reaches MOD.
module frac_accum #(
  parameter int MOD   = 25_000_000,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ACC_W-1:0] inc,
  input  logic             clear,
  input  logic             preset,
  output logic             wrap
);

  localparam logic [ACC_W-1:0] MOD_V  = ACC_W'(MOD);
  localparam logic [ACC_W-1:0] HALF_V = ACC_W'(MOD / 2);

  logic [ACC_W-1:0] phase;
  logic [ACC_W-1:0] sum;

  // inc < MOD and phase < MOD, so sum never overflows ACC_W.
  assign sum  = phase + inc;
  assign wrap = !clear && !preset && (sum >= MOD_V);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      phase <= '0;
    end else if (preset) begin
      phase <= HALF_V;
    end else if (wrap) begin
      phase <= sum - MOD_V;
    end else begin
      phase <= sum;
    end
  end

endmodule

// File: rtl/frac_baud_gen.sv
// Fractional baud generator: oversample and bit ticks from a modulo-CLK_FREQ_HZ accumulator.
// Defining FRAC_BAUD_GEN_STATS_EN adds the bit_cnt statistics output.
module frac_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 25_000_000,
  parameter int DEFAULT_BAUD = 115_200,
  parameter int OVERSAMPLE   = 16,
  parameter int ACC_W        = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        align,
  input  logic        cfg_valid,
  input  logic [31:0] cfg_baud,
  output logic        cfg_ready,
  output logic        cfg_err,
  output logic        tick_os,
  output logic        tick_bit,
  output logic [31:0] cur_baud
`ifdef FRAC_BAUD_GEN_STATS_EN
  ,
  output logic [15:0] bit_cnt
`endif
);

  localparam int              OS_W      = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF   = OS_W'(OVERSAMPLE / 2);
  localparam logic [63:0]     CLK_LIMIT = 64'(CLK_FREQ_HZ);

  if (!os_legal(OVERSAMPLE)) begin : g_bad_os
    $error("frac_baud_gen: OVERSAMPLE must be a power of two in 2..64");
  end
  if ((64'd1 << ACC_W) <= 64'd2 * CLK_LIMIT) begin : g_bad_acc
    $error("frac_baud_gen: ACC_W too narrow for CLK_FREQ_HZ");
  end

  gen_state_t       state, state_nxt;
  logic [31:0]      pend_baud;
  logic [31:0]      cur_nxt;
  logic [OS_W-1:0]  os_cnt;
  logic [ACC_W-1:0] inc;
  logic             wrap;
  logic             bit_wrap;
  logic             accept;
  logic             cfg_bad;
  logic             load_cur;

  assign inc       = ACC_W'({32'd0, cur_baud} << OS_W);
  assign cfg_ready = (state != PENDING);
  assign accept    = cfg_valid && cfg_ready;
  // Range test done at 64 bits so large requests cannot alias below the limit.
  assign cfg_bad   = (cfg_baud == 32'd0) || (({32'd0, cfg_baud} << OS_W) >= CLK_LIMIT);
  assign bit_wrap  = wrap && (os_cnt == OS_LAST);

  frac_accum #(
    .MOD   (CLK_FREQ_HZ),
    .ACC_W (ACC_W)
  ) u_accum (
    .clk    (clk),
    .rst    (rst),
    .inc    (inc),
    .clear  (!en),
    .preset (en && align),
    .wrap   (wrap)
  );

  always_comb begin
    state_nxt = state;
    load_cur  = 1'b0;
    cur_nxt   = cfg_baud;
    case (state)
      IDLE: begin
        load_cur = accept && !cfg_bad;
        if (en) state_nxt = RUN;
      end
      RUN: begin
        if (!en) begin
          state_nxt = IDLE;
          load_cur  = accept && !cfg_bad;
        end else if (accept && !cfg_bad) begin
          state_nxt = PENDING;
        end
      end
      PENDING: begin
        // New rate lands on a bit boundary, or at once if the generator stops.
        if (!en || bit_wrap) begin
          load_cur  = 1'b1;
          cur_nxt   = pend_baud;
          state_nxt = en ? RUN : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_baud  <= 32'(DEFAULT_BAUD);
      pend_baud <= 32'(DEFAULT_BAUD);
      os_cnt    <= '0;
      tick_os   <= 1'b0;
      tick_bit  <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cfg_err  <= accept && cfg_bad;
      tick_os  <= wrap;
      tick_bit <= bit_wrap;
      if (load_cur) cur_baud <= cur_nxt;
      if (accept && !cfg_bad) pend_baud <= cfg_baud;
      if (!en) begin
        os_cnt <= '0;
      end else if (align) begin
        os_cnt <= OS_HALF;
      end else if (wrap) begin
        os_cnt <= os_cnt + OS_W'(1);
      end
    end
  end

`ifdef FRAC_BAUD_GEN_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || (en && align)) begin
      bit_cnt <= '0;
    end else if (bit_wrap) begin
      bit_cnt <= bit_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/frac_baud_gen.md
FRAC_BAUD_GEN -- requirements
Module: frac_baud_gen

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 25_000_000: input clock frequency in Hz; this is the accumulator modulus.
REQ-002 SHALL have parameter DEFAULT_BAUD, default 115_200: baud rate loaded at reset.
REQ-003 SHALL have parameter OVERSAMPLE, default 16: oversample ticks per bit; power of two, range 2..64.
REQ-004 SHALL have parameter ACC_W, default 32: accumulator width; must satisfy 2^ACC_W > 2*CLK_FREQ_HZ.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port en, input, 1 bit: run enable; when low the generator is in IDLE and the phase is cleared.
REQ-008 SHALL have port align, input, 1 bit: resynchronise to mid-bit (start-bit edge).
REQ-009 SHALL have port cfg_valid, input, 1 bit: new-rate request.
REQ-010 SHALL have port cfg_baud, input, 32 bits: requested baud rate.
REQ-011 SHALL have port cfg_ready, output, 1 bit: request can be accepted.
REQ-012 SHALL have port cfg_err, output, 1 bit: one-cycle pulse when a request is rejected.
REQ-013 SHALL have port tick_os, output, 1 bit: one-cycle pulse at OVERSAMPLE*baud.
REQ-014 SHALL have port tick_bit, output, 1 bit: one-cycle pulse at baud, coincident with every OVERSAMPLE-th tick_os.
REQ-015 SHALL have port cur_baud, output, 32 bits: baud rate currently in effect.

Function
REQ-016 SHALL hold state IDLE while en=0, RUN while en=1, and PENDING while en=1 with an accepted rate change not yet applied.
REQ-017 SHALL compute the increment as cur_baud*OVERSAMPLE (shift); each RUN/PENDING cycle phase+=inc; if sum >= CLK_FREQ_HZ then phase=sum-CLK_FREQ_HZ and tick_os=1 the next cycle (registered, latency 1).
REQ-018 SHALL count tick_os pulses in an os_cnt of width log2(OVERSAMPLE); tick_bit is asserted in the same cycle as the tick_os on which os_cnt wraps from OVERSAMPLE-1 to 0.
REQ-019 SHALL, in IDLE, hold phase=0, os_cnt=0, and tick_os and tick_bit at 0.
REQ-020 SHALL, on align=1 with en=1, set phase=CLK_FREQ_HZ/2 and os_cnt=OVERSAMPLE/2 and emit no tick that cycle; align has priority over accumulation; align is ignored when en=0.
REQ-021 SHALL drive cfg_ready=1 in IDLE and RUN and 0 in PENDING; a request is accepted when cfg_valid && cfg_ready.
REQ-022 SHALL reject a request if cfg_baud==0 or cfg_baud*OVERSAMPLE >= CLK_FREQ_HZ: cfg_err pulses the next cycle, cur_baud is unchanged, and the state is unchanged.
REQ-023 SHALL, for a valid request in IDLE, update cur_baud the next cycle.
REQ-024 SHALL, for a valid request in RUN, enter PENDING and apply the new rate in the cycle tick_bit is asserted (bit boundary), then return to RUN; phase is not cleared.
REQ-025 SHALL, if en falls while in PENDING, apply the pending rate immediately and enter IDLE.
REQ-026 SHALL, if align and acceptance occur in the same cycle, perform both.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, set phase=0, os_cnt=0, tick_os=0, tick_bit=0, cfg_err=0, cur_baud=DEFAULT_BAUD, state=IDLE, and drive cfg_ready=1 from the first cycle after reset.
REQ-028 SHALL give rst priority over en, align and cfg_valid; a reset during PENDING discards the pending rate.

Configuration
REQ-029 SHALL, with FRAC_BAUD_GEN_STATS_EN defined, add output bit_cnt[15:0], which increments on each tick_bit, wraps at 0xFFFF->0, and is cleared by rst and by align.
REQ-030 SHALL, without FRAC_BAUD_GEN_STATS_EN, have no bit_cnt port and no counter logic; all other behaviour is identical.

Structure
REQ-031 SHALL place the state enum (IDLE/RUN/PENDING) and the OVERSAMPLE range-check constants in shared package uart_pkg.
REQ-032 SHALL implement the accumulator+compare as sub-module frac_accum (inputs inc, clear, preset; output wrap pulse); the FSM, os_cnt and config handshake stay in the top level.

Verification
REQ-033 SHALL verify that with defaults, en=1 for 1,000,000 cycles gives exactly 73,728 tick_os and 4,608 tick_bit, with tick_bit spacing 217 or 218 cycles.
REQ-034 SHALL verify that align pulsed mid-run gives first tick_os 7 cycles later, and that the next tick_bit occurs after exactly 8 tick_os.
REQ-035 SHALL verify that cfg_baud=9600 in RUN gives cfg_ready=0 until the next tick_bit, with cur_baud=9600 that same cycle and tick_bit spacing 2604/2605 cycles afterwards.
REQ-036 SHALL verify that cfg_baud=0 and then cfg_baud=2,000,000 each give a one-cycle cfg_err, with cur_baud remaining 115200.
REQ-037 SHALL verify that rst asserted during PENDING gives cur_baud=115200, cfg_ready=1, and no ticks during reset.
REQ-038 SHALL verify, with FRAC_BAUD_GEN_STATS_EN, that bit_cnt preset near 0xFFFF by running wraps to 0 and is cleared by align.
